// File: rtl/serial_add_seq.sv
// serial_add_seq: multi-cycle adder that adds two WIDTH-bit operands plus a
// carry-in, SLICE bits per clock, least-significant slice first. A carry
// flip-flop links the slices. Results (sum, carry-out, signed overflow) are
// registered and change only on the completion edge.
module serial_add_seq #(
   parameter int WIDTH = 8,   // operand and sum width, >= 2
   parameter int SLICE = 1    // bits added per cycle, divides WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy,
   output logic             done
);

   localparam int N  = WIDTH / SLICE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             done_q, done_d;

   // Slice adder outputs
   logic [SLICE-1:0] slice_s;
   logic             slice_c;      // carry out of the slice's top bit
   logic             slice_c_top;  // carry into the slice's top bit

   // Ripple full-adder chain over the low SLICE bits of the operand shifters
   always_comb begin
      logic c;
      c           = carry_q;
      slice_s     = '0;
      slice_c_top = carry_q;
      for (int i = 0; i < SLICE; i++) begin
         slice_c_top = c;
         slice_s[i]  = a_q[i] ^ b_q[i] ^ c;
         c           = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
      end
      slice_c = c;
   end

   // Next-state and datapath control; defaults hold every register
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            // Operands shift right so the next slice always sits at bit 0;
            // result slices enter from the top and shift down.
            a_d     = a_q >> SLICE;
            b_d     = b_q >> SLICE;
            res_d   = (res_q >> SLICE) | (WIDTH'(slice_s) << (WIDTH - SLICE));
            carry_d = slice_c;
            if (cnt_q == CW'(N - 1)) begin
               // The last slice holds the MSB, so its carries give cout/ovf
               sum_d   = res_d;
               cout_d  = slice_c;
               ovf_d   = slice_c_top ^ slice_c;
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;
   assign busy = (state_q == RUN);
   assign done = done_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed and random checks of serial_add_seq in three configurations:
// unit 0 = (8,1), unit 1 = (16,4), unit 2 = (32,8).
module tb_serial_add_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  start_v = '0;
   logic [2:0]  cin_v = '0;
   logic [2:0]  cout_v, ovf_v, busy_v, done_v;
   logic [31:0] a_s [3];
   logic [31:0] b_s [3];
   logic [7:0]  sum0;
   logic [15:0] sum1;
   logic [31:0] sum2;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   serial_add_seq #(.WIDTH(8), .SLICE(1)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_s[0][7:0]), .b(b_s[0][7:0]),
      .cin(cin_v[0]), .sum(sum0), .cout(cout_v[0]), .ovf(ovf_v[0]), .busy(busy_v[0]), .done(done_v[0]));
   serial_add_seq #(.WIDTH(16), .SLICE(4)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_s[1][15:0]), .b(b_s[1][15:0]),
      .cin(cin_v[1]), .sum(sum1), .cout(cout_v[1]), .ovf(ovf_v[1]), .busy(busy_v[1]), .done(done_v[1]));
   serial_add_seq #(.WIDTH(32), .SLICE(8)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a_s[2]), .b(b_s[2]),
      .cin(cin_v[2]), .sum(sum2), .cout(cout_v[2]), .ovf(ovf_v[2]), .busy(busy_v[2]), .done(done_v[2]));

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] get_sum(input int u);
      case (u)
         0:       return {24'h0, sum0};
         1:       return {16'h0, sum1};
         default: return sum2;
      endcase
   endfunction

   // One start pulse, then wait (bounded) for done. cyc = negedges from the
   // accepting edge until done is seen; bcnt = negedges with busy high.
   task automatic do_op(input int u, input logic [31:0] av, input logic [31:0] bv,
                        input logic ci, output int cyc, output int bcnt);
      @(negedge clk);
      a_s[u] = av; b_s[u] = bv; cin_v[u] = ci; start_v[u] = 1'b1;
      @(negedge clk);
      start_v[u] = 1'b0;
      cyc = 0; bcnt = 0;
      while (!done_v[u] && cyc < 100) begin
         if (busy_v[u]) bcnt++;
         @(negedge clk);
         cyc++;
      end
   endtask

   // Operation on a unit with full result check against hand-computed values
   task automatic dir_op(input string tag, input int u, input logic [31:0] av,
                         input logic [31:0] bv, input logic ci, input int n,
                         input logic [31:0] es, input logic ec, input logic eo);
      int cyc, bcnt;
      do_op(u, av, bv, ci, cyc, bcnt);
      check_eq({tag, "_lat"}, cyc, n);
      check_eq({tag, "_busy"}, bcnt, n);
      check_eq({tag, "_sum"}, get_sum(u), es);
      check_eq({tag, "_cout"}, cout_v[u], ec);
      check_eq({tag, "_ovf"}, ovf_v[u], eo);
      check_eq({tag, "_bsy0"}, busy_v[u], 1'b0);
      @(negedge clk);
      check_eq({tag, "_dn_drop"}, done_v[u], 1'b0);
   endtask

   initial begin
      logic [7:0] ha [28];
      logic [7:0] hb [28];
      logic       exp_done;
      int         cyc, bcnt, w;
      logic [31:0] msk, av, bv, es;
      logic [32:0] full;
      logic        ci, ec, eo;

      for (int u = 0; u < 3; u++) begin a_s[u] = '0; b_s[u] = '0; end

      // Reset then idle
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_eq("idle_done", {done_v, busy_v}, 6'b0);
      end
      check_eq("idle_sum0", sum0, 8'h00);
      check_eq("idle_sum2", sum2, 32'h0);
      check_eq("idle_co_ov", {cout_v, ovf_v}, 6'b0);

      // Basic and carry-wrap cases
      dir_op("basic", 0, 32'h3C, 32'h45, 1'b0, 8, 32'h81, 1'b0, 1'b1);
      dir_op("wrap1", 0, 32'hFF, 32'h00, 1'b1, 8, 32'h00, 1'b1, 1'b0);
      dir_op("wrap2", 0, 32'h80, 32'h80, 1'b0, 8, 32'h00, 1'b1, 1'b1);
      dir_op("pos",   0, 32'h05, 32'h0A, 1'b1, 8, 32'h10, 1'b0, 1'b0);

      // Handshake: start held high, operands change every cycle
      for (int c = 0; c < 28; c++) begin
         ha[c] = 8'(c * 17 + 3);
         hb[c] = 8'(c * 29 + 5);
      end
      @(negedge clk);
      for (int c = 0; c < 28; c++) begin
         if (c > 0) begin
            exp_done = (c % 9 == 0);
            check_eq("hs_done", done_v[0], exp_done);
            check_eq("hs_busy", busy_v[0], !exp_done);
            if (exp_done)
               check_eq("hs_sum", sum0, 8'(ha[c-9] + hb[c-9]));
            else if (c > 9)
               check_eq("hs_hold", sum0, 8'(ha[(c/9)*9-9] + hb[(c/9)*9-9]));
         end
         a_s[0] = {24'h0, ha[c]}; b_s[0] = {24'h0, hb[c]}; cin_v[0] = 1'b0;
         start_v[0] = (c < 27);
         if (c < 27) @(negedge clk);
      end
      @(negedge clk);
      check_eq("hs_dn_drop", done_v[0], 1'b0);
      check_eq("hs_idle", busy_v[0], 1'b0);

      // Reset during the 4th RUN cycle
      a_s[0] = 32'h12; b_s[0] = 32'h34; start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("mr_busy", busy_v[0], 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("mr_sum", sum0, 8'h00);
      check_eq("mr_flags", {cout_v[0], ovf_v[0], busy_v[0], done_v[0]}, 4'b0);
      repeat (3) begin
         @(negedge clk);
         check_eq("mr_nodone", done_v[0], 1'b0);
      end
      rst_n = 1'b1;
      repeat (10) begin
         @(negedge clk);
         check_eq("mr_wait", {busy_v[0], done_v[0]}, 2'b0);
      end
      dir_op("after_rst", 0, 32'h01, 32'h01, 1'b0, 8, 32'h02, 1'b0, 1'b0);

      // Other configurations, directed
      dir_op("w16", 1, 32'hFFFF, 32'h0001, 1'b0, 4, 32'h0000, 1'b1, 1'b0);
      dir_op("w16b", 1, 32'h7FFF, 32'h0000, 1'b1, 4, 32'h8000, 1'b0, 1'b1);
      dir_op("w32", 2, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 4, 32'h0, 1'b1, 1'b0);

      // Random comparison against a + b + cin
      for (int u = 0; u < 3; u++) begin
         w   = (u == 0) ? 8 : (u == 1) ? 16 : 32;
         msk = (u == 0) ? 32'hFF : (u == 1) ? 32'hFFFF : 32'hFFFF_FFFF;
         for (int k = 0; k < 1000; k++) begin
            av = $urandom & msk;
            bv = $urandom & msk;
            ci = 1'($urandom_range(0, 1));
            full = {1'b0, av} + {1'b0, bv} + {32'h0, ci};
            es = full[31:0] & msk;
            ec = full[w];
            eo = (av[w-1] == bv[w-1]) && (es[w-1] != av[w-1]);
            do_op(u, av, bv, ci, cyc, bcnt);
            check_eq("rnd_lat", cyc, (u == 0) ? 8 : 4);
            check_eq("rnd_res", {ovf_v[u], cout_v[u], get_sum(u)}, {eo, ec, es});
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
